// File: rtl/stop_watch_pkg.sv
// Shared types and digit limits for the stopwatch timekeeping datapath.
package stop_watch_pkg;

    typedef logic [3:0] bcd_t;

    // Field order matches the 24-bit display layout, minutes tens in the MSBs.
    typedef struct packed {
        bcd_t min_t;
        bcd_t min_u;
        bcd_t sec_t;
        bcd_t sec_u;
        bcd_t cs_t;
        bcd_t cs_u;
    } sw_time_t;

    localparam int unsigned SEC_T_MAX = 5;
    localparam int unsigned MIN_T_MAX = 5;
    localparam int unsigned DIGIT_MAX = 9;

endpackage

// File: rtl/stop_watch_datapath_if.sv
// Control-to-datapath bundle: FSM control strobes in, time buses and status out.
interface stop_watch_datapath_if;
    import stop_watch_pkg::*;

    logic     timming;
    logic     freezing;
    logic     reset;
    logic     update;
    sw_time_t live_time;
    sw_time_t disp_time;
    logic     tick;
    logic     overflow;

    modport master (
        output timming, freezing, reset, update,
        input  live_time, disp_time, tick, overflow
    );

    modport slave (
        input  timming, freezing, reset, update,
        output live_time, disp_time, tick, overflow
    );

endinterface

// File: rtl/bcd_digit_counter.sv
// Single BCD digit 0..MAX with synchronous clear; carry flags the wrap on this increment.
module bcd_digit_counter
    import stop_watch_pkg::*;
#(
    parameter int unsigned MAX = DIGIT_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output bcd_t digit,
    output logic carry
);

    localparam bcd_t MAX_D = 4'(MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc) begin
            digit <= (digit == MAX_D) ? '0 : digit + 4'd1;
        end
    end

    assign carry = inc && (digit == MAX_D);

endmodule

// File: rtl/stop_watch_datapath.sv
// Stopwatch datapath: centisecond prescaler, BCD mm:ss.cc chain, lap snapshot and display mux.
module stop_watch_datapath
    import stop_watch_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned TICK_HZ     = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    stop_watch_datapath_if.slave bus
);

    localparam int unsigned DIV = (TICK_HZ == 0) ? 0 : CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned REM = (TICK_HZ == 0) ? 1 : CLK_FREQ_HZ % TICK_HZ;
    localparam int unsigned PW  = (DIV < 2) ? 1 : $clog2(DIV);

    generate
        if (REM != 0 || DIV < 2) begin : g_bad_div
            $error("stop_watch_datapath: CLK_FREQ_HZ/TICK_HZ must be an integer >= 2");
        end
    endgenerate

    logic [PW-1:0] r_presc;
    logic          r_tick;
    logic          r_overflow;
    logic          r_freezing_d;
    sw_time_t      r_lap;

    logic          w_term;
    logic          w_inc;
    logic          w_snap;
    logic [5:0]    w_carry;
    bcd_t          w_cs_u, w_cs_t, w_sec_u, w_sec_t, w_min_u, w_min_t;
    sw_time_t      w_live;

    assign w_term = bus.timming && (r_presc == PW'(DIV - 1));
    assign w_inc  = w_term && !bus.reset;
    assign w_snap = (bus.freezing && !r_freezing_d) || bus.update;

    // Prescaler only advances while timming, so a pause keeps the partial period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else if (bus.reset) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else if (bus.timming) begin
            r_presc <= w_term ? '0 : r_presc + PW'(1);
            r_tick  <= w_term;
        end else begin
            r_tick  <= 1'b0;
        end
    end

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_cs_u (
        .clk(clk), .rst_n(rst_n), .clr(bus.reset), .inc(w_inc),
        .digit(w_cs_u), .carry(w_carry[0])
    );
    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_cs_t (
        .clk(clk), .rst_n(rst_n), .clr(bus.reset), .inc(w_carry[0]),
        .digit(w_cs_t), .carry(w_carry[1])
    );
    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_sec_u (
        .clk(clk), .rst_n(rst_n), .clr(bus.reset), .inc(w_carry[1]),
        .digit(w_sec_u), .carry(w_carry[2])
    );
    bcd_digit_counter #(.MAX(SEC_T_MAX)) u_sec_t (
        .clk(clk), .rst_n(rst_n), .clr(bus.reset), .inc(w_carry[2]),
        .digit(w_sec_t), .carry(w_carry[3])
    );
    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_min_u (
        .clk(clk), .rst_n(rst_n), .clr(bus.reset), .inc(w_carry[3]),
        .digit(w_min_u), .carry(w_carry[4])
    );
    bcd_digit_counter #(.MAX(MIN_T_MAX)) u_min_t (
        .clk(clk), .rst_n(rst_n), .clr(bus.reset), .inc(w_carry[4]),
        .digit(w_min_t), .carry(w_carry[5])
    );

    assign w_live = '{min_t: w_min_t, min_u: w_min_u, sec_t: w_sec_t,
                      sec_u: w_sec_u, cs_t: w_cs_t, cs_u: w_cs_u};

    // Lap captures the pre-increment count; reset outranks any snapshot request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lap        <= '0;
            r_overflow   <= 1'b0;
            r_freezing_d <= 1'b0;
        end else begin
            r_freezing_d <= bus.freezing;
            if (bus.reset) begin
                r_lap      <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_snap) begin
                    r_lap <= w_live;
                end
                if (w_carry[5]) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign bus.live_time = w_live;
    assign bus.disp_time = bus.freezing ? r_lap : w_live;
    assign bus.tick      = r_tick;
    assign bus.overflow  = r_overflow;

endmodule
